// File: rtl/fifo_word_serializer.sv
// Drains words from an FWFT FIFO and emits them MSB-first as a valid/ready byte stream,
// grouped into fixed-length frames with a last-byte marker and a completed-frame counter.
module fifo_word_serializer #(
   parameter int DATA_W      = 32,
   parameter int OUT_W       = 8,
   parameter int FRAME_WORDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic [OUT_W-1:0]  m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [15:0]       frame_cnt,
   output logic              busy
);

   // state | meaning
   // IDLE  | no word held
   // SHIFT | word held in shreg, top OUT_W bits presented on m_data

   localparam int NB = DATA_W / OUT_W;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     byte_idx;
   logic [WW-1:0]     word_idx;
   logic [15:0]       frame_cnt_q;
   logic              accept;
   logic              last_byte;
   logic              load;

   // The pop and the capture share one edge; legal only because the FIFO head is already valid.
   always_comb begin
      accept     = (state == SHIFT) && m_ready;
      last_byte  = accept && (byte_idx == BYTE_LAST);
      load       = !rst && !fifo_empty && ((state == IDLE) || last_byte);
      state_next = state;
      if (load) begin
         state_next = SHIFT;
      end else if (last_byte) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg       <= '0;
         byte_idx    <= '0;
         word_idx    <= '0;
         frame_cnt_q <= '0;
      end else begin
         if (load) begin
            shreg    <= fifo_dout;
            byte_idx <= '0;
         end else if (accept && (byte_idx != BYTE_LAST)) begin
            shreg    <= shreg << OUT_W;
            byte_idx <= byte_idx + BW'(1);
         end
         if (last_byte) begin
            if (word_idx == WORD_LAST) begin
               word_idx    <= '0;
               frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
               word_idx <= word_idx + WW'(1);
            end
         end
      end
   end

   assign fifo_rd_en = load;
   assign m_valid    = (state == SHIFT);
   assign busy       = (state == SHIFT);
   assign m_data     = shreg[DATA_W-1 -: OUT_W];
   assign m_last     = (state == SHIFT) && (byte_idx == BYTE_LAST) && (word_idx == WORD_LAST);
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: FWFT FIFO model, byte monitor, one task per scenario.
module tb_fifo_word_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_ready = 1'b0;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic [15:0] frame_cnt;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:255];
   int wp = 0;
   int rp = 0;

   logic [7:0]  log_d [0:1023];
   logic        log_l [0:1023];
   logic [15:0] log_f [0:1023];
   int          log_c [0:1023];
   int          log_n = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (wp == rp);
   assign fifo_dout  = mem[rp[7:0]];

   fifo_word_serializer #(.DATA_W(32), .OUT_W(8), .FRAME_WORDS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
   );

   // FIFO pop and accepted-byte log
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) rp <= rp + 1;
      if (!rst && m_valid && m_ready) begin
         log_d[log_n] <= m_data;
         log_l[log_n] <= m_last;
         log_f[log_n] <= frame_cnt;
         log_c[log_n] <= cyc;
         log_n        <= log_n + 1;
      end
   end

   task automatic push(input logic [31:0] w);
      mem[wp[7:0]] = w;
      wp = wp + 1;
   endtask

   task automatic short_reset();
      @(negedge clk);
      rst = 1'b1;
      m_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      push(32'h0A0B0C0D);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags cyc%0d: valid=%b busy=%b last=%b want 0", i, m_valid, busy, m_last);
         end
         total++;
         if (m_data !== 8'h00 || frame_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data cyc%0d: data=%h frame_cnt=%h want 0", i, m_data, frame_cnt);
         end
         total++;
         if (fifo_rd_en !== 1'b0 || rp !== 0) begin
            bad++;
            $display("FAIL reset_pop cyc%0d: rd_en=%b pops=%0d want 0", i, fifo_rd_en, rp);
         end
      end
   endtask

   task automatic test_single_word();
      int s;
      int pulses;
      logic [31:0] w;
      w = 32'h0A0B0C0D;
      pulses = 0;
      s = log_n;
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (fifo_rd_en === 1'b1) pulses++;
         @(negedge clk);
      end
      total++;
      if (pulses !== 1) begin
         bad++;
         $display("FAIL single_rd_pulse: got %0d cycles want 1", pulses);
      end
      total++;
      if (log_n - s !== 4) begin
         bad++;
         $display("FAIL single_count: got %0d bytes want 4", log_n - s);
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (log_d[s+k] !== w[31-8*k -: 8] || log_l[s+k] !== 1'b0 || log_f[s+k] !== 16'd0) begin
               bad++;
               $display("FAIL single_byte%0d: got %h last=%b fc=%0d want %h last=0 fc=0",
                        k, log_d[s+k], log_l[s+k], log_f[s+k], w[31-8*k -: 8]);
            end
            if (k > 0) begin
               total++;
               if (log_c[s+k] !== log_c[s] + k) begin
                  bad++;
                  $display("FAIL single_gap%0d: cycle %0d want %0d", k, log_c[s+k], log_c[s] + k);
               end
            end
         end
      end
      total++;
      if (frame_cnt !== 16'd0) begin
         bad++;
         $display("FAIL single_frame_cnt: got %0d want 0", frame_cnt);
      end
   endtask

   task automatic test_full_frame();
      int s;
      int n;
      logic [31:0] w;
      short_reset();
      for (int i = 0; i < 17; i++) push(32'(10 + i));
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      s = log_n;
      n = 0;
      while (log_n - s < 68 && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (log_n - s < 68) begin
         bad++;
         $display("FAIL frame_timeout: got %0d bytes want 68", log_n - s);
      end else begin
         for (int k = 0; k < 68; k++) begin
            w = 32'(10 + k / 4);
            total++;
            if (log_d[s+k] !== w[31-8*(k%4) -: 8]) begin
               bad++;
               $display("FAIL frame_byte%0d: got %h want %h", k, log_d[s+k], w[31-8*(k%4) -: 8]);
            end
            total++;
            if (log_l[s+k] !== (k == 63)) begin
               bad++;
               $display("FAIL frame_last%0d: got %b want %b", k, log_l[s+k], (k == 63));
            end
            if (k > 0) begin
               total++;
               if (log_c[s+k] !== log_c[s] + k) begin
                  bad++;
                  $display("FAIL frame_gap%0d: cycle %0d want %0d", k, log_c[s+k], log_c[s] + k);
               end
            end
         end
         total++;
         if (log_f[s+64] !== 16'd1) begin
            bad++;
            $display("FAIL frame_cnt_at_65: got %0d want 1", log_f[s+64]);
         end
      end
      total++;
      if (frame_cnt !== 16'd1) begin
         bad++;
         $display("FAIL frame_cnt: got %0d want 1", frame_cnt);
      end
   endtask

   task automatic test_backpressure();
      int s;
      int stalls;
      int n;
      logic prev_stall;
      logic [7:0] prev_data;
      logic prev_last;
      logic [63:0] exp;
      exp = 64'h1122334455667788;
      s = log_n;
      stalls = 0;
      prev_stall = 1'b0;
      prev_data = 8'h00;
      prev_last = 1'b0;
      @(negedge clk);
      push(32'h11223344);
      push(32'h55667788);
      n = 0;
      while (log_n - s < 8 && n < 80) begin
         m_ready = (n % 4 == 0) || (n % 4 == 3);
         #1;
         if (prev_stall) begin
            stalls++;
            total++;
            if (m_data !== prev_data || m_last !== prev_last || m_valid !== 1'b1) begin
               bad++;
               $display("FAIL bp_hold n%0d: data=%h last=%b valid=%b want %h %b 1",
                        n, m_data, m_last, m_valid, prev_data, prev_last);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data = m_data;
         prev_last = m_last;
         @(negedge clk);
         n++;
      end
      total++;
      if (log_n - s !== 8 || stalls < 4) begin
         bad++;
         $display("FAIL bp_count: got %0d bytes %0d stalls want 8 bytes >=4 stalls", log_n - s, stalls);
      end else begin
         for (int k = 0; k < 8; k++) begin
            total++;
            if (log_d[s+k] !== exp[63-8*k -: 8] || log_l[s+k] !== 1'b0) begin
               bad++;
               $display("FAIL bp_byte%0d: got %h last=%b want %h last=0", k, log_d[s+k], log_l[s+k], exp[63-8*k -: 8]);
            end
         end
      end
   endtask

   task automatic test_underflow();
      int s;
      int n;
      logic [31:0] w;
      short_reset();
      rst = 1'b0;
      m_ready = 1'b1;
      s = log_n;
      for (int i = 0; i < 3; i++) push(32'hA0000000 + 32'(i));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (i >= 15) begin
            total++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
               bad++;
               $display("FAIL uf_gap%0d: valid=%b busy=%b want 0 0", i, m_valid, busy);
            end
         end
      end
      total++;
      if (log_n - s !== 12) begin
         bad++;
         $display("FAIL uf_first_count: got %0d bytes want 12", log_n - s);
      end
      for (int i = 3; i < 16; i++) push(32'hA0000000 + 32'(i));
      n = 0;
      while (log_n - s < 64 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (log_n - s !== 64) begin
         bad++;
         $display("FAIL uf_count: got %0d bytes want 64", log_n - s);
      end else begin
         for (int k = 0; k < 64; k++) begin
            w = 32'hA0000000 + 32'(k / 4);
            total++;
            if (log_d[s+k] !== w[31-8*(k%4) -: 8] || log_l[s+k] !== (k == 63)) begin
               bad++;
               $display("FAIL uf_byte%0d: got %h last=%b want %h last=%b",
                        k, log_d[s+k], log_l[s+k], w[31-8*(k%4) -: 8], (k == 63));
            end
         end
      end
      total++;
      if (frame_cnt !== 16'd1) begin
         bad++;
         $display("FAIL uf_frame_cnt: got %0d want 1", frame_cnt);
      end
   endtask

   task automatic test_reset_mid_word();
      int s;
      int n;
      int rsave;
      int lsave;
      logic [31:0] w;
      m_ready = 1'b1;
      s = log_n;
      for (int i = 0; i < 6; i++) push(32'hB0000000 + 32'(i));
      n = 0;
      while (log_n - s < 18 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (log_n - s !== 18) begin
         bad++;
         $display("FAIL rm_pre_count: got %0d bytes want 18", log_n - s);
      end
      rst = 1'b1;
      m_ready = 1'b0;
      #1;
      rsave = rp;
      lsave = log_n;
      total++;
      if (fifo_rd_en !== 1'b0) begin
         bad++;
         $display("FAIL rm_rd_en_in_rst: got %b want 0", fifo_rd_en);
      end
      @(negedge clk);
      #1;
      total++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || frame_cnt !== 16'd0) begin
         bad++;
         $display("FAIL rm_clear: valid=%b busy=%b last=%b data=%h fc=%0d want all 0",
                  m_valid, busy, m_last, m_data, frame_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (fifo_rd_en !== 1'b0 || rp !== rsave || log_n !== lsave) begin
            bad++;
            $display("FAIL rm_hold%0d: rd_en=%b pops=%0d bytes=%0d want 0 %0d %0d",
                     i, fifo_rd_en, rp, log_n, rsave, lsave);
         end
      end
      for (int i = 6; i < 21; i++) push(32'hB0000000 + 32'(i));
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      s = log_n;
      n = 0;
      while (log_n - s < 64 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (log_n - s !== 64) begin
         bad++;
         $display("FAIL rm_count: got %0d bytes want 64", log_n - s);
      end else begin
         for (int k = 0; k < 64; k++) begin
            w = 32'hB0000000 + 32'(5 + k / 4);
            total++;
            if (log_d[s+k] !== w[31-8*(k%4) -: 8] || log_l[s+k] !== (k == 63)) begin
               bad++;
               $display("FAIL rm_byte%0d: got %h last=%b want %h last=%b",
                        k, log_d[s+k], log_l[s+k], w[31-8*(k%4) -: 8], (k == 63));
            end
         end
      end
      total++;
      if (frame_cnt !== 16'd1) begin
         bad++;
         $display("FAIL rm_frame_cnt: got %0d want 1", frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_frame();
      test_backpressure();
      test_underflow();
      test_reset_mid_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Drains 32-bit words from the first-word-fall-through (FWFT) measurement FIFO and emits them as a byte stream on a valid/ready interface, MSB first. The block sits directly downstream of the FIFO read port, on the FIFO read clock. It feeds the host-side byte pipe. It groups words into fixed-length frames, marks the last byte of each frame, and counts completed frames.

## Interface
- `DATA_W`, default 32: FIFO word width; must be a multiple of `OUT_W`.
- `OUT_W`, default 8: output byte width.
- `FRAME_WORDS`, default 16: words per frame, ≥1.
- `clk`  in  1  single clock; also drives the FIFO `rd_clk`.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_dout`  in  DATA_W  FWFT head word; valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop strobe; combinational.
- `m_data`  out  OUT_W  output byte.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts the byte when `m_valid` && `m_ready`.
- `m_last`  out  1  qualifies the last byte of a frame.
- `frame_cnt`  out  16  count of completed frames; wraps at 2^16.
- `busy`  out  1  a word is held in the shift register.

## Operation
- Constants:
  - NB = DATA_W/OUT_W, which is 4 at defaults.
  - `byte_idx` counts 0..NB-1.
  - `word_idx` counts 0..FRAME_WORDS-1.
- States:
  - IDLE: no word held.
  - SHIFT: word held in `shreg`.
- Define `accept` = `m_valid` && `m_ready`.
- Define `last_byte` = `accept` && `byte_idx`==NB-1.
- Define `load` = !`rst` && !`fifo_empty` && (state==IDLE || `last_byte`).
- `fifo_rd_en` = `load`.
  - Never asserted while `fifo_empty`=1.
  - Never asserted while `rst`=1.
- On `load`:
  - `shreg` <= `fifo_dout`.
  - `byte_idx` <= 0.
  - state <= SHIFT.
  - The pop and the capture happen on the same edge, which is legal because the FIFO is FWFT.
- In SHIFT:
  - `m_valid`=1 and `m_data` = `shreg`[DATA_W-1 -: OUT_W].
  - On `accept` with `byte_idx`<NB-1: shift `shreg` left by OUT_W and increment `byte_idx`.
- On `last_byte`:
  - `word_idx` increments. If it was FRAME_WORDS-1, it wraps to 0 and `frame_cnt` increments.
  - If there is no `load` in the same cycle, state <= IDLE.
- `m_last` = SHIFT && `byte_idx`==NB-1 && `word_idx`==FRAME_WORDS-1.
- `busy` = (state==SHIFT).
- Boundary conditions:
  - FIFO empty in the middle of a frame: return to IDLE and hold `word_idx`. The frame continues when data returns; no timeout applies.
  - FIFO empty at `last_byte`: no pop; drop to IDLE.
  - Backpressure: while `m_valid` && !`m_ready`, `m_data`, `m_last`, `byte_idx` and `shreg` are all held stable.
  - `frame_cnt` at 16'hFFFF wraps to 0 on the next completed frame.
  - Reset mid-word: the held word is discarded (not re-read), and `word_idx` is cleared. FIFO contents are untouched because `fifo_rd_en`=0 during reset.

## Timing
- Reset values (all outputs are driven during `rst`):
  - state=IDLE.
  - `m_valid`=0, `m_last`=0, `busy`=0.
  - `m_data`=0 and `shreg`=0.
  - `byte_idx`=0, `word_idx`=0, `frame_cnt`=0.
  - `fifo_rd_en`=0.
- Latency: the first byte of a word is valid in the cycle after the `fifo_rd_en` edge.
- Throughput with `m_ready` held at 1 and the FIFO non-empty is one byte per cycle:
  - The next pop coincides with the acceptance of the last byte, so there are no bubbles between words.
  - One word takes NB cycles.
  - One frame takes NB·FRAME_WORDS cycles.
- Combinational paths:
  - `fifo_rd_en` depends combinationally on `m_ready` and `fifo_empty`.
  - `m_valid`, `m_data`, `m_last` and `busy` are register outputs (or decodes of registers only).
- `rst` takes priority over every other event in the same cycle.

## Test plan
- Reset state: assert `rst` for 40 cycles with the FIFO non-empty.
  - All outputs are at their reset values throughout.
  - `fifo_rd_en` stays 0.
  - The FIFO count is unchanged.
- Single word: push 32'h0A0B0C0D with `m_ready`=1.
  - `fifo_rd_en` pulses for exactly 1 cycle.
  - Bytes 0A, 0B, 0C, 0D appear on 4 consecutive cycles.
  - `m_last`=0 and `frame_cnt`=0.
- Full frame: push 16 words of values 10..25, then a 17th word, with `m_ready`=1.
  - 64 gap-free bytes: 00,00,00,0A ... 00,00,00,19.
  - `m_last` is high only on byte 64.
  - `frame_cnt`=1.
  - The 17th word starts at byte 65 with `word_idx`=0.
- Backpressure: 2 words with `m_ready` toggling 1,0,0,1,…
  - No byte is lost or duplicated.
  - `m_data` is stable on every stall cycle.
  - Output order is preserved.
- Underflow mid-frame: push 3 words, wait 20 cycles, then push 13 more.
  - `m_valid`=0 during the gap.
  - `m_last` is asserted on the final byte of the 16th word.
  - `frame_cnt`=1.
- Reset mid-word: assert `rst` after the 2nd byte of word 5.
  - Outputs clear on the next edge.
  - After release, the next FIFO word is emitted with `word_idx`=0.
  - No pop occurs during reset.
